// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scb_if.sv
// Read/write/issue/clear bus of the scoreboarded register file.
interface regfile_scb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              rd_busy_1;
    logic              rd_busy_2;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output rd_addr_1, rd_addr_2, we, wr_addr, wr_data, iss_valid, iss_addr, clr_req,
        input  rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, clr_busy
    );

    modport slave (
        input  rd_addr_1, rd_addr_2, we, wr_addr, wr_data, iss_valid, iss_addr, clr_req,
        output rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, clr_busy
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register producer-pending bits: set on issue, cleared by a completing write or the clear sweep.
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_accept,
    input  logic [ADDR_W-1:0]    iss_addr,
    input  logic                 wr_accept,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    output logic [2**ADDR_W-1:0] pending_q
);

    logic [2**ADDR_W-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (wr_accept) begin
            pending_d[wr_addr] = 1'b0;
        end
        // Issue is applied last so a same-cycle issue and write leave the new producer pending.
        if (iss_accept) begin
            pending_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Two-read/one-write register file with write forwarding, producer scoreboard and a clear sweep.
module regfile_scb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_scb_if.slave bus
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic              ZERO_EN = (ZERO_REG != 0);
    localparam logic              BYP_EN  = (BYPASS != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              clearing;
    logic              wr_accept;
    logic              iss_accept;
    logic              hit_1, hit_2;
    logic [DATA_W-1:0] rd_data_1, rd_data_2;

    assign clearing   = (state_q == CLEAR);
    assign wr_accept  = bus.we & ~clearing & ~(ZERO_EN & (bus.wr_addr == '0));
    assign iss_accept = bus.iss_valid & ~clearing & ~(ZERO_EN & (bus.iss_addr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (wr_accept) begin
                    regs_d[bus.wr_addr] = bus.wr_data;
                end
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_accept (iss_accept),
        .iss_addr   (bus.iss_addr),
        .wr_accept  (wr_accept),
        .wr_addr    (bus.wr_addr),
        .clr_en     (clearing),
        .clr_addr   (cnt_q),
        .pending_q  (pending)
    );

    // wr_accept is already low during a sweep, so forwarding is naturally off then.
    always_comb begin
        hit_1     = BYP_EN & wr_accept & (bus.wr_addr == bus.rd_addr_1);
        hit_2     = BYP_EN & wr_accept & (bus.wr_addr == bus.rd_addr_2);
        rd_data_1 = hit_1 ? bus.wr_data : regs_q[bus.rd_addr_1];
        rd_data_2 = hit_2 ? bus.wr_data : regs_q[bus.rd_addr_2];
        if (ZERO_EN && (bus.rd_addr_1 == '0)) begin
            rd_data_1 = '0;
        end
        if (ZERO_EN && (bus.rd_addr_2 == '0)) begin
            rd_data_2 = '0;
        end
    end

    assign bus.rd_data_1 = rd_data_1;
    assign bus.rd_data_2 = rd_data_2;
    assign bus.rd_busy_1 = pending[bus.rd_addr_1] & ~hit_1;
    assign bus.rd_busy_2 = pending[bus.rd_addr_2] & ~hit_2;
    assign bus.clr_busy  = clearing;

endmodule

// File: tb/tb_regfile_scb.sv
// Directed plus randomized checks of regfile_scb (bypass, no-bypass and 64x8 variants)
// against a behavioural register-file model.
module tb_regfile_scb;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_scb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_scb_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();
    regfile_scb_if #(.DATA_W(64), .ADDR_W(3)) bus_w ();

    // The no-bypass copy sees exactly the same stimulus as the main DUT.
    assign bus_nb.rd_addr_1 = bus.rd_addr_1;
    assign bus_nb.rd_addr_2 = bus.rd_addr_2;
    assign bus_nb.we        = bus.we;
    assign bus_nb.wr_addr   = bus.wr_addr;
    assign bus_nb.wr_data   = bus.wr_data;
    assign bus_nb.iss_valid = bus.iss_valid;
    assign bus_nb.iss_addr  = bus.iss_addr;
    assign bus_nb.clr_req   = bus.clr_req;

    regfile_scb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_scb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
        dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));
    regfile_scb #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
        dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    logic [31:0] m_mem  [32];
    bit          m_pend [32];
    int          m_clr_left, m_clr_idx;
    logic [63:0] w_mem  [8];
    int          w_clr_left, w_clr_idx;

    function automatic bit accWr();
        return bus.we && (m_clr_left == 0) && (bus.wr_addr != 5'd0);
    endfunction

    function automatic bit accWrW();
        return bus_w.we && (w_clr_left == 0) && (bus_w.wr_addr != 3'd0);
    endfunction

    function automatic logic [31:0] expRd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && accWr() && bus.wr_addr == a) return bus.wr_data;
        return m_mem[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit byp);
        return m_pend[a] && !(byp && accWr() && bus.wr_addr == a);
    endfunction

    function automatic logic [63:0] expRdW(input logic [2:0] a);
        if (a == 3'd0) return 64'd0;
        if (accWrW() && bus_w.wr_addr == a) return bus_w.wr_data;
        return w_mem[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) w_mem[i] = '0;
        m_clr_left = 0;
        m_clr_idx  = 0;
        w_clr_left = 0;
        w_clr_idx  = 0;
    endtask

    // Advances the model by one clock using the inputs held across the edge.
    task automatic modelStep();
        bit aw, ai, aww;
        aw  = accWr();
        ai  = bus.iss_valid && (m_clr_left == 0) && (bus.iss_addr != 5'd0);
        aww = accWrW();
        if (m_clr_left > 0) begin
            m_mem[m_clr_idx]  = '0;
            m_pend[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (aw) begin
                m_mem[bus.wr_addr]  = bus.wr_data;
                m_pend[bus.wr_addr] = 1'b0;
            end
            if (ai) m_pend[bus.iss_addr] = 1'b1;
            if (bus.clr_req) begin
                m_clr_left = 32;
                m_clr_idx  = 0;
            end
        end
        if (w_clr_left > 0) begin
            w_mem[w_clr_idx] = '0;
            w_clr_idx++;
            w_clr_left--;
        end else begin
            if (aww) w_mem[bus_w.wr_addr] = bus_w.wr_data;
            if (bus_w.clr_req) begin
                w_clr_left = 8;
                w_clr_idx  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string ph);
        #1;
        checkOutput({ph, ".rd_data_1"}, bus.rd_data_1, expRd(bus.rd_addr_1, 1'b1));
        checkOutput({ph, ".rd_data_2"}, bus.rd_data_2, expRd(bus.rd_addr_2, 1'b1));
        checkOutput({ph, ".rd_busy_1"}, bus.rd_busy_1, expBusy(bus.rd_addr_1, 1'b1));
        checkOutput({ph, ".rd_busy_2"}, bus.rd_busy_2, expBusy(bus.rd_addr_2, 1'b1));
        checkOutput({ph, ".clr_busy"}, bus.clr_busy, m_clr_left > 0);
        checkOutput({ph, ".nb.rd_data_1"}, bus_nb.rd_data_1, expRd(bus.rd_addr_1, 1'b0));
        checkOutput({ph, ".nb.rd_data_2"}, bus_nb.rd_data_2, expRd(bus.rd_addr_2, 1'b0));
        checkOutput({ph, ".nb.rd_busy_1"}, bus_nb.rd_busy_1, expBusy(bus.rd_addr_1, 1'b0));
        checkOutput({ph, ".nb.rd_busy_2"}, bus_nb.rd_busy_2, expBusy(bus.rd_addr_2, 1'b0));
        checkOutput({ph, ".nb.clr_busy"}, bus_nb.clr_busy, m_clr_left > 0);
        checkOutput({ph, ".w.rd_data_1"}, bus_w.rd_data_1, expRdW(bus_w.rd_addr_1));
        checkOutput({ph, ".w.rd_data_2"}, bus_w.rd_data_2, expRdW(bus_w.rd_addr_2));
        checkOutput({ph, ".w.clr_busy"}, bus_w.clr_busy, w_clr_left > 0);
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [4:0] ia, input logic clr,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        bus.we        = w;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.iss_valid = iv;
        bus.iss_addr  = ia;
        bus.clr_req   = clr;
        bus.rd_addr_1 = ra1;
        bus.rd_addr_2 = ra2;
    endtask

    task automatic applyW(input logic w, input logic [2:0] wa, input logic [63:0] wd,
                          input logic clr, input logic [2:0] ra1, input logic [2:0] ra2);
        bus_w.we        = w;
        bus_w.wr_addr   = wa;
        bus_w.wr_data   = wd;
        bus_w.clr_req   = clr;
        bus_w.rd_addr_1 = ra1;
        bus_w.rd_addr_2 = ra2;
    endtask

    task automatic drainClear();
        for (int i = 0; i < 40 && (m_clr_left > 0 || w_clr_left > 0); i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
            checkAll("drain");
            step();
        end
    endtask

    initial begin
        int          cnt;
        logic [63:0] wv;

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        applyW(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 3'd0);
        bus_w.iss_valid = 1'b0;
        bus_w.iss_addr  = 3'd0;
        rst = 1'b1;
        #2 rst = 1'b0;
        modelReset();
        checkAll("in_reset");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] reset state");
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(31 - a));
            applyW(1'b0, 3'd0, 64'd0, 1'b0, 3'(a), 3'(7 - a));
            checkAll("post_reset");
            checkOutput("post_reset.rd_data_1.zero", bus.rd_data_1, 64'd0);
        end

        $display("[TB] write/read r5, r0");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        checkAll("wr_r5");
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        checkAll("rd_r5");
        checkOutput("rd_r5.const", bus.rd_data_1, 64'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkAll("wr_r0");
        checkOutput("wr_r0.bypass_blocked", bus.rd_data_1, 64'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        checkAll("rd_r0");
        checkOutput("rd_r0.const", bus.rd_data_1, 64'd0);
        step();

        $display("[TB] forwarding r7");
        applyStimulus(1'b1, 5'd7, 32'hAAAA5555, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkAll("pre_r7");
        step();
        applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        checkAll("byp_r7");
        checkOutput("byp_r7.bypass", bus.rd_data_2, 64'h12345678);
        checkOutput("byp_r7.no_bypass", bus_nb.rd_data_2, 64'hAAAA5555);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        checkAll("post_r7");
        checkOutput("post_r7.no_bypass", bus_nb.rd_data_2, 64'h12345678);

        $display("[TB] scoreboard r3");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        checkAll("iss_r3");
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        checkAll("busy_r3");
        checkOutput("busy_r3.const", bus.rd_busy_1, 64'd1);
        applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        checkAll("wr_r3");
        checkOutput("wr_r3.bypass_busy", bus.rd_busy_1, 64'd0);
        checkOutput("wr_r3.no_bypass_busy", bus_nb.rd_busy_1, 64'd1);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        checkAll("clr_r3");
        checkOutput("clr_r3.busy", bus_nb.rd_busy_1, 64'd0);
        applyStimulus(1'b1, 5'd3, 32'h00000034, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        checkAll("isswr_r3");
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        checkAll("isswr_r3_after");
        checkOutput("isswr_r3.busy", bus.rd_busy_1, 64'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom),
                          ($urandom_range(0, 63) == 0), 5'($urandom), 5'($urandom));
            checkAll("random");
            step();
        end
        drainClear();

        $display("[TB] full sweep");
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), $urandom | 32'h1, 1'b0, 5'd0, 1'b0, 5'(a), 5'd0);
            checkAll("fill");
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd31);
        checkAll("sweep_start");
        step();
        cnt = 0;
        for (int i = 0; i < 64 && bus.clr_busy; i++) begin
            applyStimulus(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom),
                          (i < 16), 5'($urandom), 5'($urandom));
            checkAll("sweep");
            cnt++;
            step();
        end
        checkOutput("sweep_len", 64'(cnt), 64'd32);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(a));
            checkAll("post_sweep");
            checkOutput("post_sweep.zero", bus.rd_data_1, 64'd0);
            checkOutput("post_sweep.idle_busy", {bus.rd_busy_1, bus.clr_busy}, 64'd0);
        end

        $display("[TB] reset mid-sweep");
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), 32'hA000_0000 | 32'(a), 1'b1, 5'(32 - a), 1'b0, 5'(a), 5'd0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 5'd31);
        step();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd31);
            checkAll("abort_sweep");
            step();
        end
        rst = 1'b0;
        modelReset();
        checkAll("abort_rst");
        checkOutput("abort_rst.clr_busy", bus.clr_busy, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(a));
            checkAll("abort_after");
        end
        for (int a = 1; a < 5; a++) begin
            applyStimulus(1'b1, 5'(a), 32'hB000_0000 | 32'(a), 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1, 5'd2);
        checkAll("restart");
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
            checkAll("restart_sweep");
            if (i == 1) checkOutput("restart.r2_kept", bus.rd_data_2, 64'hB000_0002);
            step();
        end
        drainClear();

        $display("[TB] 64-bit / 8-entry variant");
        for (int a = 1; a < 8; a++) begin
            wv = {$urandom, $urandom};
            applyW(1'b1, 3'(a), wv, 1'b0, 3'(a - 1), 3'd0);
            checkAll("w_fill");
            step();
            applyW(1'b0, 3'd0, 64'd0, 1'b0, 3'(a), 3'd0);
            checkAll("w_read");
            checkOutput("w_read.round_trip", bus_w.rd_data_1, wv);
        end
        applyW(1'b0, 3'd0, 64'd0, 1'b1, 3'd7, 3'd3);
        checkAll("w_sweep_start");
        step();
        cnt = 0;
        for (int i = 0; i < 32 && bus_w.clr_busy; i++) begin
            applyW(1'b1, 3'($urandom), {$urandom, $urandom}, 1'b0, 3'($urandom), 3'($urandom));
            checkAll("w_sweep");
            cnt++;
            step();
        end
        checkOutput("w_sweep_len", 64'(cnt), 64'd8);
        for (int a = 0; a < 8; a++) begin
            applyW(1'b0, 3'd0, 64'd0, 1'b0, 3'(a), 3'(a));
            checkAll("w_post_sweep");
            checkOutput("w_post_sweep.zero", bus_w.rd_data_1, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
